// File: rtl/alu_mp_seq.sv
// Multi-precision sequencer for the shared 8-bit ALU: runs one NBYTES-wide
// operation as back-to-back byte slices, LSB first, chaining the carry.
module alu_mp_seq #(
    parameter int NBYTES = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [2:0]            op,
    input  logic [8*NBYTES-1:0]   opa,
    input  logic [8*NBYTES-1:0]   opb,
    input  logic                  cin,
    output logic                  ready,
    output logic                  done,
    output logic [8*NBYTES-1:0]   result,
    output logic                  cout,
    output logic                  zero,
    output logic [2:0]            alu_oper,
    output logic [7:0]            alu_a,
    output logic [7:0]            alu_b,
    output logic                  alu_c_in,
    input  logic                  alu_c_out,
    input  logic [7:0]            alu_sum
);

    localparam int W    = 8 * NBYTES;
    localparam int IDXW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NBYTES - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t            state, state_next;
    logic [IDXW-1:0]   idx;
    logic [IDXW+2:0]   bit_base;
    logic [2:0]        op_q;
    logic [W-1:0]      opa_q, opb_q;
    logic              cin_q;
    logic              carry_q;
    logic [W-1:0]      next_result;
    logic              last_slice;

    assign bit_base   = {idx, 3'b000};
    assign last_slice = (idx == LAST_IDX);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (last_slice) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Slice idx+1 and up get the previous slice's carry; 010 pre-inverts it
    // because the ALU inverts c_in for b-a, and logic ops get no carry.
    always_comb begin
        ready    = (state == IDLE);
        done     = (state == DONE);
        alu_oper = 3'b000;
        alu_a    = 8'h00;
        alu_b    = 8'h00;
        alu_c_in = 1'b0;
        if (state == RUN) begin
            alu_oper = op_q;
            alu_a    = opa_q[bit_base +: 8];
            alu_b    = opb_q[bit_base +: 8];
            if (idx == '0) begin
                alu_c_in = cin_q;
            end else begin
                case (op_q)
                    3'b000, 3'b001: alu_c_in = carry_q;
                    3'b010:         alu_c_in = ~carry_q;
                    default:        alu_c_in = 1'b0;
                endcase
            end
        end
    end

    always_comb begin
        next_result                = result;
        next_result[bit_base +: 8] = alu_sum;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx     <= '0;
            op_q    <= 3'b000;
            opa_q   <= '0;
            opb_q   <= '0;
            cin_q   <= 1'b0;
            carry_q <= 1'b0;
            result  <= '0;
            cout    <= 1'b0;
            zero    <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        op_q  <= op;
                        opa_q <= opa;
                        opb_q <= opb;
                        cin_q <= cin;
                        idx   <= '0;
                    end
                end
                RUN: begin
                    result  <= next_result;
                    carry_q <= alu_c_out;
                    if (last_slice) begin
                        idx  <= '0;
                        cout <= alu_c_out;
                        zero <= (next_result == '0);
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_mp_seq.sv
// Self-checking bench for alu_mp_seq with a behavioural 8-bit ALU and a
// wide-arithmetic reference model.
module tb_alu_mp_seq;

    localparam int N = 4;
    localparam int W = 8 * N;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [2:0]    op;
    logic [W-1:0]  opa, opb;
    logic          cin;
    logic          ready, done, cout, zero;
    logic [W-1:0]  result;
    logic [2:0]    alu_oper;
    logic [7:0]    alu_a, alu_b, alu_sum;
    logic          alu_c_in, alu_c_out;
    logic [8:0]    alu_t;

    int total = 0;
    int bad   = 0;

    alu_mp_seq #(.NBYTES(N)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .opa(opa), .opb(opb),
        .cin(cin), .ready(ready), .done(done), .result(result), .cout(cout),
        .zero(zero), .alu_oper(alu_oper), .alu_a(alu_a), .alu_b(alu_b),
        .alu_c_in(alu_c_in), .alu_c_out(alu_c_out), .alu_sum(alu_sum)
    );

    always #5 clk = ~clk;

    // The shared ALU: b-a inverts its carry-in, logic ops never carry.
    always_comb begin
        alu_t = 9'h000;
        case (alu_oper)
            3'b000: alu_t = {1'b0, alu_a} + {1'b0, alu_b} + {8'h00, alu_c_in};
            3'b001: alu_t = {1'b0, alu_a} + {1'b0, ~alu_b} + {8'h00, alu_c_in};
            3'b010: alu_t = {1'b0, alu_b} + {1'b0, ~alu_a} + {8'h00, ~alu_c_in};
            3'b011: alu_t = {1'b0, alu_a | alu_b};
            3'b100: alu_t = {1'b0, alu_a & alu_b};
            3'b101: alu_t = {1'b0, ~alu_a & alu_b};
            3'b110: alu_t = {1'b0, alu_a ^ alu_b};
            default: alu_t = {1'b0, ~(alu_a ^ alu_b)};
        endcase
    end
    assign alu_sum   = alu_t[7:0];
    assign alu_c_out = alu_t[8];

    task automatic check_w(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_b(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic check_i(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Whole-width reference: the chained slices must equal one wide operation.
    task automatic ref_calc(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic c, output logic [W-1:0] res, output logic co);
        logic [W:0] s;
        case (o)
            3'b000: s = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
            3'b001: s = {1'b0, a} + {1'b0, ~b} + {{W{1'b0}}, c};
            3'b010: s = {1'b0, b} + {1'b0, ~a} + {{W{1'b0}}, ~c};
            3'b011: s = {1'b0, a | b};
            3'b100: s = {1'b0, a & b};
            3'b101: s = {1'b0, ~a & b};
            3'b110: s = {1'b0, a ^ b};
            default: s = {1'b0, ~(a ^ b)};
        endcase
        res = s[W-1:0];
        co  = s[W];
    endtask

    task automatic run_op(input string tag, input logic [2:0] o, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic c, input bit glitch,
                          input bit check_exp, input logic [W-1:0] exp_res, input logic exp_co);
        logic [W-1:0] mres;
        logic         mco;
        logic         cin_ok, slice_ok;
        int           n;
        ref_calc(o, a, b, c, mres, mco);
        if (check_exp) begin
            check_w({tag, "_model"}, mres, exp_res);
            check_b({tag, "_model_co"}, mco, exp_co);
        end
        @(negedge clk);
        start = 1'b1; op = o; opa = a; opb = b; cin = c;
        @(posedge clk);
        slice_ok = 1'b1;
        cin_ok   = 1'b1;
        n = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            start = 1'b0;
            opa = $urandom; opb = $urandom; op = 3'($urandom_range(0, 7)); cin = 1'($urandom_range(0, 1));
            if (done) begin
                n = k;
                break;
            end
            if (k <= N) begin
                if (alu_oper !== o || alu_a !== a[8*(k-1) +: 8] || alu_b !== b[8*(k-1) +: 8] || ready !== 1'b0)
                    slice_ok = 1'b0;
                if (k == 1 && alu_c_in !== c) cin_ok = 1'b0;
                if (k > 1 && o >= 3'b011 && alu_c_in !== 1'b0) cin_ok = 1'b0;
            end
            if (glitch && k == 2) start = 1'b1;
        end
        check_b({tag, "_slices"}, slice_ok, 1'b1);
        check_b({tag, "_cin"}, cin_ok, 1'b1);
        check_i({tag, "_latency"}, n, N + 1);
        check_w({tag, "_result"}, result, mres);
        check_b({tag, "_cout"}, cout, mco);
        check_b({tag, "_zero"}, zero, (mres == '0));
        @(negedge clk);
        check_b({tag, "_done_1cyc"}, done, 1'b0);
        check_b({tag, "_ready"}, ready, 1'b1);
        check_w({tag, "_held"}, result, mres);
    endtask

    initial begin
        logic [W-1:0] ra, rb, mres;
        logic [2:0]   ro;
        logic         rc, mco, seen_done;
        int           t1, t2, cyc;

        rst = 1'b1; start = 1'b0; op = 3'b000; opa = '0; opb = '0; cin = 1'b0;
        repeat (3) @(negedge clk);
        check_b("rst_ready", ready, 1'b1);
        check_b("rst_done", done, 1'b0);
        check_w("rst_result", result, '0);
        check_b("rst_zero", zero, 1'b1);
        check_b("rst_cout", cout, 1'b0);
        check_w("rst_alu", {21'b0, alu_oper, alu_a}, '0);
        rst = 1'b0;
        @(negedge clk);

        run_op("add_ripple", 3'b000, 32'h000000FF, 32'h00000001, 1'b0, 0, 1, 32'h00000100, 1'b0);
        run_op("sub_borrow", 3'b001, 32'h00000000, 32'h00000001, 1'b1, 0, 1, 32'hFFFFFFFF, 1'b0);
        run_op("sub_equal",  3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 0, 1, 32'h00000000, 1'b1);
        run_op("rsub_a",     3'b010, 32'h00000001, 32'h00000010, 1'b0, 0, 1, 32'h0000000F, 1'b1);
        run_op("rsub_b",     3'b010, 32'h00000100, 32'h00000001, 1'b0, 0, 1, 32'hFFFFFF01, 1'b0);
        run_op("xor_zero",   3'b110, 32'hA5A5A5A5, 32'hA5A5A5A5, 1'b1, 0, 1, 32'h00000000, 1'b0);
        run_op("andn",       3'b101, 32'hF0F0F0F0, 32'hFFFFFFFF, 1'b1, 0, 1, 32'h0F0F0F0F, 1'b0);
        run_op("ignore_start", 3'b000, 32'h12345678, 32'h11111111, 1'b0, 1, 1, 32'h23456789, 1'b0);

        // Held start: accepts must be NBYTES+2 cycles apart.
        @(negedge clk);
        start = 1'b1; op = 3'b000; opa = 32'h01020304; opb = 32'h10203040; cin = 1'b0;
        t1 = -1; t2 = -1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (done && t1 < 0) t1 = k;
            else if (done && t2 < 0) t2 = k;
            if (t2 >= 0) break;
        end
        check_i("b2b_period", t2 - t1, N + 2);
        check_w("b2b_result", result, 32'h11223344);
        start = 1'b0;
        cyc = 0;
        while (!ready && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        check_b("b2b_idle", ready, 1'b1);

        // Reset in the second RUN cycle.
        @(negedge clk);
        start = 1'b1; op = 3'b000; opa = 32'hFFFFFFFF; opb = 32'h00000001; cin = 1'b0;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_b("mid_rst_ready", ready, 1'b1);
        check_w("mid_rst_result", result, '0);
        check_b("mid_rst_zero", zero, 1'b1);
        check_w("mid_rst_alu", {21'b0, alu_oper, alu_a}, '0);
        @(negedge clk);
        rst = 1'b0;
        seen_done = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (done) seen_done = 1'b1;
        end
        check_b("mid_rst_no_done", seen_done, 1'b0);
        run_op("after_rst", 3'b000, 32'hFFFFFFFF, 32'h00000001, 1'b0, 0, 1, 32'h00000000, 1'b1);

        for (int i = 0; i < 24; i++) begin
            ro = 3'($urandom_range(0, 7));
            ra = $urandom;
            rb = (i % 4 == 0) ? ra : $urandom;
            rc = 1'($urandom_range(0, 1));
            ref_calc(ro, ra, rb, rc, mres, mco);
            run_op("rand", ro, ra, rb, rc, 0, 0, mres, mco);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_mp_seq.md
Name: alu_mp_seq

Overview:
- Multi-precision sequencer for the shared 8-bit ALU (3-bit op, carry in/out).
- Runs one NBYTES-wide operation as NBYTES back-to-back byte slices, least-significant byte first, and chains the carry between slices.
- Drives the ALU ports directly and assembles the wide result, final carry and zero flag.
- Sits between the datapath control and the ALU; start/ready/done handshake.

Parameters:
- NBYTES, 4, number of byte slices per operation (≥1); operand/result width is 8*NBYTES.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous reset, active-high
- start  in  1  request; accepted only when ready=1
- op  in  3  ALU operation code; same encoding as the ALU (000 add, 001 a-b, 010 b-a, 011 or, 100 and, 101 ~a&b, 110 xor, 111 xnor)
- opa  in  8*NBYTES  operand A
- opb  in  8*NBYTES  operand B
- cin  in  1  carry-in for slice 0
- ready  out  1  high in IDLE
- done  out  1  one-cycle pulse; result valid
- result  out  8*NBYTES  assembled result, held until next accepted start
- cout  out  1  ALU c_out of final slice
- zero  out  1  result == 0
- alu_oper  out  3  to ALU oper
- alu_a  out  8  to ALU a
- alu_b  out  8  to ALU b
- alu_c_in  out  1  to ALU c_in
- alu_c_out  in  1  from ALU c_out (combinational)
- alu_sum  in  8  from ALU sum (combinational)

Behaviour:
- Reset (async, any time including mid-operation): state=IDLE, byte index=0, ready=1, done=0, result=0, cout=0, zero=1, alu_* outputs=0, latched operands cleared.
- FSM states: IDLE, RUN, DONE.
  - IDLE: ready=1. If start=1 at a clock edge: latch op/opa/opb/cin, set idx=0, go to RUN.
  - RUN: ready=0. Each cycle presents slice idx to the ALU. At the edge: capture alu_sum into result[8*idx+7:8*idx], capture alu_c_out into a carry register, and increment idx. After slice NBYTES-1 is captured, go to DONE.
  - DONE: one cycle, done=1, ready=0; then go to IDLE.
- Latency: start edge E0 → slices captured at E1..E(NBYTES) → done high for the cycle after E(NBYTES) → ready=1 after E(NBYTES+1). Default NBYTES=4: 6 clock edges from start to the next accept.
- ALU drive in RUN:
  - alu_oper = latched op.
  - alu_a / alu_b = byte idx of latched opa / opb.
- Carry chaining (c_prev = captured c_out of slice idx-1):
  - Slice 0: alu_c_in = latched cin for every op.
  - Slices ≥1, op 000/001: alu_c_in = c_prev.
  - Slices ≥1, op 010: alu_c_in = ~c_prev, because the ALU inverts c_in for this op.
  - Slices ≥1, logic ops 011–111: alu_c_in = 0.
- Outside RUN, alu_oper/alu_a/alu_b/alu_c_in = 0.
- Result fields:
  - result bytes not yet written during RUN keep their values from the previous operation.
  - result/cout/zero are final only when done=1 and hold until the next accepted start.
  - cout = c_out of the final slice, raw: 1 means no borrow for 001/010, and is always 0 for logic ops.
  - zero is registered together with the final slice and reflects the full assembled result.
- start while ready=0 is ignored, with no queuing. start held high continuously re-triggers on each IDLE cycle.
- Operand inputs are sampled only at the accept edge; later changes have no effect on the running operation.
- Boundary case NBYTES=1: RUN lasts one cycle; the chaining rules apply to slice 0 only.

Test Plan:
- Add with carry ripple (NBYTES=4): op=000, opa=0x000000FF, opb=0x00000001, cin=0 → result=0x00000100, cout=0, zero=0. done asserted exactly one cycle, 4 cycles after the start edge; ready returns the next cycle.
- Subtract with borrow through all bytes: op=001, opa=0x00000000, opb=0x00000001, cin=1 → result=0xFFFFFFFF, cout=0. Also opa=0xFFFFFFFF, opb=0xFFFFFFFF, cin=1 → result=0, cout=1, zero=1.
- Reverse subtract chaining: op=010, opa=0x00000001, opb=0x00000010, cin=0 → result=0x0000000F, cout=1. Also opa=0x00000100, opb=0x00000001, cin=0 → result=0xFFFFFF01, cout=0.
- Logic ops: op=110, opa=opb=0xA5A5A5A5 → result=0, zero=1, cout=0. op=101, opa=0xF0F0F0F0, opb=0xFFFFFFFF → result=0x0F0F0F0F. alu_c_in=0 on slices 1–3.
- Handshake: pulse start during RUN with different operands → ignored, result unchanged. Hold start high → back-to-back operations, one every NBYTES+2 cycles.
- Reset mid-operation: assert rst in the second RUN cycle → immediately state IDLE, ready=1, result=0, zero=1, done never pulses. The next start completes normally.
